// File: rtl/uncached_dbus_axi.sv
// Single-beat AXI4 master for uncached CPU data accesses: each stalled load/store
// becomes exactly one 32-bit AXI transaction, then stall drops for one cycle.
package uncached_dbus_axi_pkg;
   typedef struct packed {
      logic [31:0] araddr;
      logic [7:0]  arlen;
      logic [2:0]  arsize;
      logic [1:0]  arburst;
      logic        arlock;
      logic [3:0]  arcache;
      logic [2:0]  arprot;
      logic        arvalid;
      logic        rready;
      logic [31:0] awaddr;
      logic [7:0]  awlen;
      logic [2:0]  awsize;
      logic [1:0]  awburst;
      logic        awlock;
      logic [3:0]  awcache;
      logic [2:0]  awprot;
      logic        awvalid;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        wlast;
      logic        wvalid;
      logic        bready;
   } axi_req_t;

   typedef struct packed {
      logic        arready;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      logic        rlast;
      logic        rvalid;
      logic        awready;
      logic        wready;
      logic [1:0]  bresp;
      logic        bvalid;
   } axi_resp_t;
endpackage

module uncached_dbus_axi
   import uncached_dbus_axi_pkg::*;
#(
   parameter logic [3:0] CACHE_ATTR = 4'b0000,
   parameter logic [2:0] PROT_ATTR  = 3'b000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dbus_read_i,
   input  logic        dbus_write_i,
   input  logic [31:0] dbus_address_i,
   input  logic [31:0] dbus_wrdata_i,
   input  logic [3:0]  dbus_byteenable_i,
   output logic        dbus_stall_o,
   output logic [31:0] dbus_rddata_o,
   output axi_req_t    axi_req_o,
   input  axi_resp_t   axi_resp_i
);
   typedef enum logic [2:0] {IDLE, AR, R, WR, B, DONE} state_t;

   state_t      state_q;
   logic        aw_done_q, w_done_q;
   logic [31:0] addr_q, wrdata_q, rddata_q;
   logic [3:0]  be_q;

   logic awvalid, wvalid, aw_hs, w_hs;

   // Valids come from state and handshake flags only, never from slave inputs.
   assign awvalid = (state_q == WR) && !aw_done_q;
   assign wvalid  = (state_q == WR) && !w_done_q;
   assign aw_hs   = awvalid && axi_resp_i.awready;
   assign w_hs    = wvalid  && axi_resp_i.wready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         addr_q    <= '0;
         wrdata_q  <= '0;
         be_q      <= '0;
         rddata_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (dbus_write_i) begin
                  addr_q   <= dbus_address_i;
                  wrdata_q <= dbus_wrdata_i;
                  be_q     <= dbus_byteenable_i;
                  state_q  <= WR;
               end else if (dbus_read_i) begin
                  addr_q  <= dbus_address_i;
                  state_q <= AR;
               end
            end
            AR: if (axi_resp_i.arready) state_q <= R;
            R: begin
               if (axi_resp_i.rvalid) begin
                  rddata_q <= axi_resp_i.rdata;
                  state_q  <= DONE;
               end
            end
            WR: begin
               if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                  aw_done_q <= 1'b0;
                  w_done_q  <= 1'b0;
                  state_q   <= B;
               end else begin
                  if (aw_hs) aw_done_q <= 1'b1;
                  if (w_hs)  w_done_q  <= 1'b1;
               end
            end
            B:       if (axi_resp_i.bvalid) state_q <= DONE;
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dbus_stall_o  = ((state_q == IDLE) && (dbus_read_i || dbus_write_i)) ||
                          ((state_q != IDLE) && (state_q != DONE));
   assign dbus_rddata_o = rddata_q;

   always_comb begin
      axi_req_o         = '0;
      axi_req_o.araddr  = addr_q;
      axi_req_o.arsize  = 3'b010;
      axi_req_o.arburst = 2'b01;
      axi_req_o.arcache = CACHE_ATTR;
      axi_req_o.arprot  = PROT_ATTR;
      axi_req_o.arvalid = (state_q == AR);
      axi_req_o.rready  = (state_q == R);
      axi_req_o.awaddr  = addr_q;
      axi_req_o.awsize  = 3'b010;
      axi_req_o.awburst = 2'b01;
      axi_req_o.awcache = CACHE_ATTR;
      axi_req_o.awprot  = PROT_ATTR;
      axi_req_o.awvalid = awvalid;
      axi_req_o.wdata   = wrdata_q;
      axi_req_o.wstrb   = be_q;
      axi_req_o.wlast   = wvalid;
      axi_req_o.wvalid  = wvalid;
      axi_req_o.bready  = (state_q == B);
   end

   // Responses and rlast carry no information for single-beat uncached accesses.
   logic unused_resp;
   assign unused_resp = ^{axi_resp_i.rresp, axi_resp_i.rlast, axi_resp_i.bresp};
endmodule

// File: tb/tb_uncached_dbus_axi.sv
// Bench for uncached_dbus_axi: randomized AXI slave with per-channel wait states
// and a transaction-level model of expected handshakes, latency and read data.
module tb_uncached_dbus_axi;
   import uncached_dbus_axi_pkg::*;

   localparam logic [3:0] CA = 4'b0011;
   localparam logic [2:0] PA = 3'b010;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rd = 1'b0, wr = 1'b0;
   logic [31:0] addr = '0, wdat = '0;
   logic [3:0]  be = '0;
   logic        stall;
   logic [31:0] rddata;
   axi_req_t    req;
   axi_resp_t   rsp;

   int total = 0, bad = 0;

   // slave configuration and observation
   int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
   logic [31:0] rdata_val = '0;
   int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   int ar_vc = 0, aw_vc = 0, w_vc = 0;
   int ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0, fld_bad = 0;
   logic [31:0] ar_log[$], aw_log[$];
   logic [36:0] w_log[$];
   logic [31:0] last_rd = '0;

   always #5 clk = ~clk;

   uncached_dbus_axi #(.CACHE_ATTR(CA), .PROT_ATTR(PA)) dut (
      .clk(clk), .rst(rst),
      .dbus_read_i(rd), .dbus_write_i(wr), .dbus_address_i(addr),
      .dbus_wrdata_i(wdat), .dbus_byteenable_i(be),
      .dbus_stall_o(stall), .dbus_rddata_o(rddata),
      .axi_req_o(req), .axi_resp_i(rsp)
   );

   // Slave: readies/valids set on the falling edge, handshakes recorded there too.
   always @(negedge clk) begin
      if (rst) begin
         rsp = '0;
         ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end else begin
         rsp.arready = 1'b0;
         if (req.arvalid) begin
            ar_vc++;
            if (ar_cnt >= ar_dly) begin
               rsp.arready = 1'b1; ar_cnt = 0; ar_hs++;
               ar_log.push_back(req.araddr);
               if (req.arlen != 0 || req.arsize != 3'b010 || req.arburst != 2'b01 ||
                   req.arlock != 0 || req.arcache != CA || req.arprot != PA) fld_bad++;
            end else ar_cnt++;
         end else ar_cnt = 0;

         rsp.rvalid = 1'b0;
         rsp.rdata  = $urandom;
         if (req.rready) begin
            if (r_cnt >= r_dly) begin
               rsp.rvalid = 1'b1; rsp.rdata = rdata_val; rsp.rresp = 2'($urandom);
               rsp.rlast = 1'b1; r_cnt = 0; r_hs++;
            end else r_cnt++;
         end else r_cnt = 0;

         rsp.awready = 1'b0;
         if (req.awvalid) begin
            aw_vc++;
            if (aw_cnt >= aw_dly) begin
               rsp.awready = 1'b1; aw_cnt = 0; aw_hs++;
               aw_log.push_back(req.awaddr);
               if (req.awlen != 0 || req.awsize != 3'b010 || req.awburst != 2'b01 ||
                   req.awlock != 0 || req.awcache != CA || req.awprot != PA) fld_bad++;
            end else aw_cnt++;
         end else aw_cnt = 0;

         rsp.wready = 1'b0;
         if (req.wvalid) begin
            w_vc++;
            if (w_cnt >= w_dly) begin
               rsp.wready = 1'b1; w_cnt = 0; w_hs++;
               w_log.push_back({req.wdata, req.wstrb, req.wlast});
            end else w_cnt++;
         end else w_cnt = 0;

         rsp.bvalid = 1'b0;
         if (req.bready) begin
            if (b_cnt >= b_dly) begin
               rsp.bvalid = 1'b1; rsp.bresp = 2'($urandom); b_cnt = 0; b_hs++;
            end else b_cnt++;
         end else b_cnt = 0;
      end
   end

   // Drive one CPU request (called at a falling edge) and hold it until stall drops.
   task automatic issue(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        output int scyc, output logic [31:0] rdv, output logic ok);
      ar_vc = 0; aw_vc = 0; w_vc = 0;
      ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
      ar_log.delete(); aw_log.delete(); w_log.delete();
      rd = r; wr = w; addr = a; wdat = d; be = b;
      scyc = 0; ok = 1'b0; rdv = '0;
      for (int i = 0; i < 200; i++) begin
         #1;
         if (!stall) begin rdv = rddata; ok = 1'b1; break; end
         scyc++;
         @(negedge clk);
      end
      @(negedge clk);
      rd = 1'b0; wr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      total++;
      if ({req.arvalid, req.rready, req.awvalid, req.wvalid, req.bready} !== 5'b0) begin
         bad++; $display("FAIL reset_valids got=%b exp=00000",
            {req.arvalid, req.rready, req.awvalid, req.wvalid, req.bready});
      end
      total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
      total++;
      if (rddata !== 32'h0) begin bad++; $display("FAIL reset_rddata got=%h exp=0", rddata); end
      rd = 1'b1;
      #1;
      total++;
      if (stall !== 1'b1) begin bad++; $display("FAIL reset_stall_req got=%b exp=1", stall); end
      rd = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_read_basic();
      int sc; logic [31:0] rv; logic ok;
      ar_dly = 0; r_dly = 0; rdata_val = 32'hDEADBEEF;
      issue(1'b1, 1'b0, 32'h1FD0_03F8, 32'h0, 4'h0, sc, rv, ok);
      last_rd = rdata_val;
      total++;
      if (!ok || sc != 3) begin bad++; $display("FAIL read_stall got=%0d ok=%b exp=3", sc, ok); end
      total++;
      if (rv !== 32'hDEADBEEF) begin bad++; $display("FAIL read_data got=%h exp=deadbeef", rv); end
      total++;
      if (ar_vc != 1 || ar_hs != 1 || r_hs != 1 || aw_hs != 0) begin
         bad++; $display("FAIL read_hs got=arvc%0d ar%0d r%0d aw%0d exp=1,1,1,0", ar_vc, ar_hs, r_hs, aw_hs);
      end
      total++;
      if (ar_log.size() != 1 || ar_log[0] !== 32'h1FD0_03F8 || fld_bad != 0) begin
         bad++; $display("FAIL read_addr got=%h fld_bad=%0d exp=1fd003f8", ar_log.size() ? ar_log[0] : 32'hx, fld_bad);
      end
   endtask

   task automatic test_write_aw_delay();
      int sc; logic [31:0] rv; logic ok;
      aw_dly = 3; w_dly = 0; b_dly = 0;
      issue(1'b0, 1'b1, 32'hBFC0_0010, 32'h1234_5678, 4'b0011, sc, rv, ok);
      total++;
      if (!ok || sc != 6) begin bad++; $display("FAIL wr_stall got=%0d ok=%b exp=6", sc, ok); end
      total++;
      if (aw_vc != 4 || w_vc != 1) begin bad++; $display("FAIL wr_valid_cycles got=aw%0d w%0d exp=aw4 w1", aw_vc, w_vc); end
      total++;
      if (w_log.size() != 1 || w_log[0] !== {32'h1234_5678, 4'b0011, 1'b1}) begin
         bad++; $display("FAIL wr_wbeat got=%h exp=%h", w_log.size() ? w_log[0] : 37'hx, {32'h1234_5678, 4'b0011, 1'b1});
      end
      total++;
      if (aw_log.size() != 1 || aw_log[0] !== 32'hBFC0_0010 || b_hs != 1 || ar_hs != 0 || fld_bad != 0) begin
         bad++; $display("FAIL wr_aw_b got=aw%0d b%0d ar%0d fld%0d exp=1,1,0,0", aw_hs, b_hs, ar_hs, fld_bad);
      end
      total++;
      if (rv !== last_rd) begin bad++; $display("FAIL wr_rddata_hold got=%h exp=%h", rv, last_rd); end
   endtask

   task automatic test_w_aw_order();
      int sc; logic [31:0] rv; logic ok;
      int cfg[3][3] = '{'{2, 0, 1}, '{0, 2, 0}, '{0, 0, 2}};
      for (int k = 0; k < 3; k++) begin
         aw_dly = cfg[k][0]; w_dly = cfg[k][1]; b_dly = cfg[k][2];
         issue(1'b0, 1'b1, 32'h1000_0000 + 32'(k * 4), 32'hA5A5_0000 + 32'(k), 4'hF, sc, rv, ok);
         total++;
         if (!ok || sc != 3 + (aw_dly > w_dly ? aw_dly : w_dly) + b_dly) begin
            bad++; $display("FAIL order%0d_stall got=%0d exp=%0d", k, sc, 3 + (aw_dly > w_dly ? aw_dly : w_dly) + b_dly);
         end
         total++;
         if (aw_vc != aw_dly + 1 || w_vc != w_dly + 1 || aw_hs != 1 || w_hs != 1 || b_hs != 1) begin
            bad++; $display("FAIL order%0d_hs got=awvc%0d wvc%0d aw%0d w%0d b%0d exp=%0d,%0d,1,1,1",
               k, aw_vc, w_vc, aw_hs, w_hs, b_hs, aw_dly + 1, w_dly + 1);
         end
      end
   endtask

   task automatic test_back_to_back();
      int sc; logic [31:0] rv; logic ok;
      logic [31:0] a, d;
      ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
      for (int k = 0; k < 3; k++) begin
         a = {$urandom, 2'b00} & 32'hFFFF_FFFC; d = $urandom; rdata_val = $urandom;
         issue(k == 0 || k == 2, k == 1, a, d, 4'hF, sc, rv, ok);
         if (k != 1) last_rd = rdata_val;
         total++;
         if (!ok || sc != 3 || rv !== last_rd) begin
            bad++; $display("FAIL b2b%0d got=sc%0d rd=%h exp=sc3 rd=%h", k, sc, rv, last_rd);
         end
         total++;
         if ((k == 1) ? (aw_hs != 1 || w_hs != 1 || ar_hs != 0 || aw_log[0] !== a || w_log[0][36:5] !== d)
                      : (ar_hs != 1 || aw_hs != 0 || ar_log[0] !== a)) begin
            bad++; $display("FAIL b2b%0d_txn got=ar%0d aw%0d w%0d exp_addr=%h", k, ar_hs, aw_hs, w_hs, a);
         end
      end
   endtask

   task automatic test_reset_mid();
      int sc; logic [31:0] rv; logic ok;
      logic seen = 1'b0;
      ar_dly = 0; r_dly = 50;
      rd = 1'b1; addr = 32'h2000_0040;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk); #1;
         seen = req.rready;
      end
      total++;
      if (!seen) begin bad++; $display("FAIL rstmid_reach_r got=0 exp=1"); end
      rst = 1'b1;
      @(negedge clk); #1;
      total++;
      if ({req.arvalid, req.rready, req.awvalid, req.wvalid, req.bready} !== 5'b0 || stall !== 1'b1) begin
         bad++; $display("FAIL rstmid_idle got=%b stall=%b exp=00000 stall=1",
            {req.arvalid, req.rready, req.awvalid, req.wvalid, req.bready}, stall);
      end
      rd = 1'b0; rst = 1'b0; last_rd = '0; r_dly = 0;
      @(negedge clk);
      rdata_val = 32'h0BAD_F00D;
      issue(1'b1, 1'b0, 32'h2000_0044, 32'h0, 4'h0, sc, rv, ok);
      last_rd = rdata_val;
      total++;
      if (!ok || sc != 3 || rv !== 32'h0BAD_F00D || ar_hs != 1 || ar_log[0] !== 32'h2000_0044) begin
         bad++; $display("FAIL rstmid_read got=sc%0d rd=%h ar%0d exp=sc3 rd=0badf00d ar1", sc, rv, ar_hs);
      end
   endtask

   task automatic test_rw_both();
      int sc; logic [31:0] rv; logic ok;
      aw_dly = 0; w_dly = 0; b_dly = 0;
      issue(1'b1, 1'b1, 32'h3000_0008, 32'hCAFE_0001, 4'b1000, sc, rv, ok);
      total++;
      if (!ok || sc != 3 || ar_vc != 0 || ar_hs != 0 || aw_hs != 1 || w_hs != 1 || b_hs != 1) begin
         bad++; $display("FAIL rw_both got=sc%0d arvc%0d aw%0d w%0d b%0d exp=sc3 0,1,1,1", sc, ar_vc, aw_hs, w_hs, b_hs);
      end
      total++;
      if (w_log[0] !== {32'hCAFE_0001, 4'b1000, 1'b1} || aw_log[0] !== 32'h3000_0008) begin
         bad++; $display("FAIL rw_both_payload got=%h exp=%h", w_log[0], {32'hCAFE_0001, 4'b1000, 1'b1});
      end
   endtask

   task automatic test_random();
      int sc, exp_sc; logic [31:0] rv, a, d; logic [3:0] b; logic ok, isw;
      for (int k = 0; k < 24; k++) begin
         isw = 1'($urandom); a = $urandom & 32'hFFFF_FFFC; d = $urandom; b = 4'($urandom);
         ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
         aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
         rdata_val = $urandom;
         exp_sc = isw ? 3 + (aw_dly > w_dly ? aw_dly : w_dly) + b_dly : 3 + ar_dly + r_dly;
         issue(!isw, isw, a, d, b, sc, rv, ok);
         if (!isw) last_rd = rdata_val;
         total++;
         if (!ok || sc != exp_sc || rv !== last_rd) begin
            bad++; $display("FAIL rnd%0d got=sc%0d rd=%h exp=sc%0d rd=%h", k, sc, rv, exp_sc, last_rd);
         end
         total++;
         if (isw ? (aw_hs != 1 || w_hs != 1 || b_hs != 1 || ar_hs != 0 || aw_log[0] !== a ||
                    w_log[0] !== {d, b, 1'b1} || aw_vc != aw_dly + 1 || w_vc != w_dly + 1)
                 : (ar_hs != 1 || r_hs != 1 || aw_hs != 0 || ar_log[0] !== a || ar_vc != ar_dly + 1)) begin
            bad++; $display("FAIL rnd%0d_txn got=ar%0d r%0d aw%0d w%0d b%0d exp_addr=%h write=%b",
               k, ar_hs, r_hs, aw_hs, w_hs, b_hs, a, isw);
         end
      end
      total++;
      if (fld_bad != 0) begin bad++; $display("FAIL fixed_fields got=%0d exp=0", fld_bad); end
   endtask

   initial begin
      test_reset();
      test_read_basic();
      test_write_aw_delay();
      test_w_aw_order();
      test_back_to_back();
      test_reset_mid();
      test_rw_both();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
